key_injector: RTL and testbench

//   Keypad emulator: transmit side of the 20-line keypad interface.
//   - Accepts 5-bit key codes over a valid/ready handshake and queues them in a small FIFO.
//   - Replays each code on a one-hot 20-bit key bus as a timed press (HOLD_TICKS) then release (GAP_TICKS).
//   - The key bus feeds the keypad encoder/synchroniser exactly as physical buttons would.
//   - Used for scripted input (demo/attract mode, replay) and for self-test of the input path.
//

---
 rtl/key_injector.sv | 191 +++++++++++++++++++
 tb/tb_key_injector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_injector.sv
// Keypad emulator: queues 5-bit key codes and replays each one as a timed press then release on a one-hot key bus.
// Optional build macro KEYINJ_DONE_EN adds the done/done_code release report outputs.
module key_injector #(
    parameter int NKEYS      = 20,
    parameter int CODE_W     = 5,
    parameter int DEPTH      = 4,
    parameter int HOLD_TICKS = 3,
    parameter int GAP_TICKS  = 2
) (
    input  logic                         hz100,
    input  logic                         reset,
    input  logic [CODE_W-1:0]            code_in,
    input  logic                         code_valid,
    output logic                         code_ready,
    output logic [NKEYS-1:0]             keys_out,
    output logic                         busy,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef KEYINJ_DONE_EN
    ,
    output logic                         done,
    output logic [CODE_W-1:0]            done_code
`endif
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int MAX_T = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [CODE_W:0]    KEY_LIM   = (CODE_W + 1)'(NKEYS);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]   LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]   LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NKEYS-1:0]    r_keys;
    logic [NKEYS-1:0]    w_keys_nxt;
    logic                r_err;
    logic [CODE_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;

    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_in_range;
    logic                w_push;
    logic                w_pop;
    logic [CODE_W-1:0]   w_head;

    // Ready depends only on occupancy, so a same-cycle pop never lets a code through early.
    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == LVL_ZERO);
    assign w_accept   = code_valid & ~w_full;
    assign w_in_range = ({1'b0, code_in} < KEY_LIM);
    assign w_push     = w_accept & w_in_range;
    assign w_head     = r_mem[r_rd_ptr];

    assign code_ready = ~w_full;
    assign keys_out   = r_keys;
    assign busy       = ~w_empty | (r_state != S_IDLE);
    assign err        = r_err;
    assign level      = r_level;

    // Press/release sequencer: next state, counter, key bus and FIFO pop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_keys_nxt  = r_keys;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRESS: begin
                if (r_cnt == CNT_ZERO) begin
                    w_keys_nxt  = {NKEYS{1'b0}};
                    w_cnt_nxt   = GAP_LOAD;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_ZERO) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_keys_nxt  = {NKEYS{1'b0}};
            end
        endcase
        if (w_pop) begin
            w_state_nxt = S_PRESS;
            w_cnt_nxt   = HOLD_LOAD;
            w_keys_nxt  = NKEYS'(1) << w_head;
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // Sequencer state, key bus and error pulse registers.
    always_ff @(posedge hz100) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_keys  <= {NKEYS{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_keys  <= w_keys_nxt;
            r_err   <= w_accept & ~w_in_range;
        end
    end

    // FIFO pointers and occupancy; storage is left unreset since pointers define validity.
    always_ff @(posedge hz100) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= LVL_ZERO;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= code_in;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef KEYINJ_DONE_EN
    logic [CODE_W-1:0] r_cur_code;
    logic              r_done;
    logic [CODE_W-1:0] r_done_code;

    assign done      = r_done;
    assign done_code = r_done_code;

    // Release report: remember the pressed code, publish it on the PRESS->GAP edge.
    always_ff @(posedge hz100) begin
        if (reset) begin
            r_cur_code  <= {CODE_W{1'b0}};
            r_done      <= 1'b0;
            r_done_code <= {CODE_W{1'b0}};
        end else begin
            if (w_pop) begin
                r_cur_code <= w_head;
            end
            r_done <= (r_state == S_PRESS) && (r_cnt == CNT_ZERO);
            if ((r_state == S_PRESS) && (r_cnt == CNT_ZERO)) begin
                r_done_code <= r_cur_code;
            end
        end
    end
`endif

endmodule

// File: tb/tb_key_injector.sv
// Self-checking bench for key_injector: scoreboard of accepted codes checked against presses seen on keys_out.
module tb_key_injector;

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  code_in = 5'd0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [19:0] keys_out;
    logic        busy;
    logic        err;
    logic [2:0]  level;
`ifdef KEYINJ_DONE_EN
    logic        done;
    logic [4:0]  done_code;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];

    key_injector dut (
        .hz100      (hz100),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .keys_out   (keys_out),
        .busy       (busy),
        .err        (err),
        .level      (level)
`ifdef KEYINJ_DONE_EN
        ,
        .done       (done),
        .done_code  (done_code)
`endif
    );

    always #5 hz100 = ~hz100;

    // Press monitor: one-hot, acceptance order, hold length, minimum gap.
    initial begin
        logic [19:0] m_prev;
        logic [19:0] m_exp;
        int m_hold;
        int m_gap;
        bit m_have;
        m_prev = 20'd0; m_hold = 0; m_gap = 0; m_have = 1'b0;
        forever begin
            @(negedge hz100);
            if (reset) begin
                m_prev = 20'd0; m_hold = 0; m_gap = 0; m_have = 1'b0;
            end else begin
                if ($countones(keys_out) > 1) begin
                    n_tests++; n_fail++;
                    $display("FAIL mon_onehot: keys_out=0x%05h has more than one bit", keys_out);
                end
                if (keys_out != 20'd0 && m_prev == 20'd0) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_order: got keys_out=0x%05h, expected no press", keys_out);
                    end else begin
                        m_exp = 20'd1 << sb.pop_front();
                        if (keys_out !== m_exp) begin
                            n_fail++;
                            $display("FAIL mon_order: got keys_out=0x%05h, expected 0x%05h", keys_out, m_exp);
                        end
                    end
                    if (m_have) begin
                        n_tests++;
                        if (m_gap < 2) begin
                            n_fail++;
                            $display("FAIL mon_gap: got %0d zero cycles, expected at least 2", m_gap);
                        end
                    end
                    m_hold = 1;
                end else if (keys_out != 20'd0) begin
                    if (keys_out !== m_prev) begin
                        n_tests++; n_fail++;
                        $display("FAIL mon_stable: got 0x%05h, expected 0x%05h", keys_out, m_prev);
                    end
                    m_hold++;
                end else if (m_prev != 20'd0) begin
                    n_tests++;
                    if (m_hold != 3) begin
                        n_fail++;
                        $display("FAIL mon_hold: got %0d cycles, expected 3", m_hold);
                    end
                    m_gap = 1; m_have = 1'b1;
                end else begin
                    m_gap++;
                end
                m_prev = keys_out;
            end
        end
    end

    task automatic push(input logic [4:0] c);
        bit ok;
        ok = 1'b0;
        code_in = c;
        code_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge hz100);
            if (code_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: code %0d, ready=%0b, expected ready=1", c, code_ready);
        end else begin
            @(posedge hz100);
            if (c < 5'd20) sb.push_back(int'(c));
        end
        #1;
        code_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge hz100);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, expected busy=0 pending=0", busy, sb.size());
        end
        @(posedge hz100);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        code_valid = 1'b0;
        repeat (2) @(posedge hz100);
        #1;
        n_tests++; if (keys_out !== 20'd0) begin n_fail++; $display("FAIL reset_keys: got 0x%05h, expected 0", keys_out); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, expected 0", level); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, expected 0", err); end
        n_tests++; if (code_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b, expected 1", code_ready); end
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_single();
        logic [19:0] exp;
        push(5'd7);
        n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d, expected 1", level); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b, expected 1", busy); end
        n_tests++; if (keys_out !== 20'd0) begin n_fail++; $display("FAIL single_lat: got 0x%05h, expected 0", keys_out); end
        for (int k = 1; k <= 6; k++) begin
            @(posedge hz100);
            #1;
            exp = (k <= 3) ? 20'h00080 : 20'h00000;
            n_tests++;
            if (keys_out !== exp) begin
                n_fail++;
                $display("FAIL single_keys: edge %0d got 0x%05h, expected 0x%05h", k, keys_out, exp);
            end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%0b, expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int codes[3];
        int idx;
        logic [19:0] exp;
        codes[0] = 0; codes[1] = 19; codes[2] = 5;
        push(5'd0);
        push(5'd19);
        push(5'd5);
        for (int k = 2; k <= 16; k++) begin
            if (k > 2) begin
                @(posedge hz100);
                #1;
            end
            idx = (k - 1) / 5;
            exp = (idx < 3 && ((k - 1) % 5) < 3) ? (20'd1 << codes[idx]) : 20'd0;
            n_tests++;
            if (keys_out !== exp) begin
                n_fail++;
                $display("FAIL b2b_keys: edge %0d got 0x%05h, expected 0x%05h", k, keys_out, exp);
            end
        end
        wait_idle();
    endtask

    task automatic test_full();
        push(5'd1);
        push(5'd2);
        push(5'd3);
        push(5'd4);
        push(5'd5);
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d, expected 4", level); end
        n_tests++; if (code_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b, expected 0", code_ready); end
        push(5'd6);
        wait_idle();
    endtask

    task automatic test_err();
        logic [4:0] bad[2];
        bad[0] = 5'd20; bad[1] = 5'd31;
        for (int j = 0; j < 2; j++) begin
            push(bad[j]);
            n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: code %0d got err=%0b, expected 1", bad[j], err); end
            n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL err_level: code %0d got %0d, expected 0", bad[j], level); end
            @(posedge hz100);
            #1;
            n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_width: code %0d got err=%0b, expected 0", bad[j], err); end
            n_tests++; if (keys_out !== 20'd0) begin n_fail++; $display("FAIL err_keys: got 0x%05h, expected 0", keys_out); end
        end
    endtask

    task automatic test_reset_press();
        push(5'd4);
        push(5'd9);
        push(5'd13);
        n_tests++; if (keys_out !== 20'h00010) begin n_fail++; $display("FAIL rstp_press: got 0x%05h, expected 0x00010", keys_out); end
        n_tests++; if (level !== 3'd2) begin n_fail++; $display("FAIL rstp_level: got %0d, expected 2", level); end
        reset = 1'b1;
        @(posedge hz100);
        #1;
        n_tests++; if (keys_out !== 20'd0) begin n_fail++; $display("FAIL rstp_keys: got 0x%05h, expected 0", keys_out); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL rstp_flush: got %0d, expected 0", level); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstp_idle: got busy=%0b, expected 0", busy); end
        reset = 1'b0;
        sb.delete();
        repeat (3) @(posedge hz100);
        #1;
        n_tests++; if (keys_out !== 20'd0) begin n_fail++; $display("FAIL rstp_lost: got 0x%05h, expected 0", keys_out); end
    endtask

`ifdef KEYINJ_DONE_EN
    task automatic test_done();
        push(5'd12);
        for (int k = 1; k <= 6; k++) begin
            @(posedge hz100);
            #1;
            n_tests++;
            if (done !== (k == 4)) begin
                n_fail++;
                $display("FAIL done_pulse: edge %0d got %0b, expected %0b", k, done, (k == 4));
            end
            if (k >= 4) begin
                n_tests++;
                if (done_code !== 5'd12) begin
                    n_fail++;
                    $display("FAIL done_code: edge %0d got %0d, expected 12", k, done_code);
                end
            end
        end
        wait_idle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_err();
        test_reset_press();
`ifdef KEYINJ_DONE_EN
        test_done();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
